// File: rtl/chip8_kbd_pkg.sv
// Shared constants for the PS/2 to CHIP-8 keypad bridge.
// Holds the set-2 scancodes of the 16 hex keys and the two function keys,
// plus a decoder from scancode to {hit, chip8 key}.
package chip8_kbd_pkg;

  // Row 1: 1 2 3 4 -> 1 2 3 C
  localparam logic [7:0] ScKey1 = 8'h16;
  localparam logic [7:0] ScKey2 = 8'h1E;
  localparam logic [7:0] ScKey3 = 8'h26;
  localparam logic [7:0] ScKey4 = 8'h25;
  // Row 2: Q W E R -> 4 5 6 D
  localparam logic [7:0] ScKeyQ = 8'h15;
  localparam logic [7:0] ScKeyW = 8'h1D;
  localparam logic [7:0] ScKeyE = 8'h24;
  localparam logic [7:0] ScKeyR = 8'h2D;
  // Row 3: A S D F -> 7 8 9 E
  localparam logic [7:0] ScKeyA = 8'h1C;
  localparam logic [7:0] ScKeyS = 8'h1B;
  localparam logic [7:0] ScKeyD = 8'h23;
  localparam logic [7:0] ScKeyF = 8'h2B;
  // Row 4: Z X C V -> A 0 B F
  localparam logic [7:0] ScKeyZ = 8'h1A;
  localparam logic [7:0] ScKeyX = 8'h22;
  localparam logic [7:0] ScKeyC = 8'h21;
  localparam logic [7:0] ScKeyV = 8'h2A;

  // Front-panel function keys
  localparam logic [7:0] ScF1  = 8'h05;
  localparam logic [7:0] ScF12 = 8'h07;

  // Returns {hit, key}; hit=0 for anything outside the hex block.
  function automatic logic [4:0] hex_decode(input logic [7:0] sc);
    logic [4:0] res;
    res = 5'b0;
    case (sc)
      ScKey1: res = {1'b1, 4'h1};
      ScKey2: res = {1'b1, 4'h2};
      ScKey3: res = {1'b1, 4'h3};
      ScKey4: res = {1'b1, 4'hC};
      ScKeyQ: res = {1'b1, 4'h4};
      ScKeyW: res = {1'b1, 4'h5};
      ScKeyE: res = {1'b1, 4'h6};
      ScKeyR: res = {1'b1, 4'hD};
      ScKeyA: res = {1'b1, 4'h7};
      ScKeyS: res = {1'b1, 4'h8};
      ScKeyD: res = {1'b1, 4'h9};
      ScKeyF: res = {1'b1, 4'hE};
      ScKeyZ: res = {1'b1, 4'hA};
      ScKeyX: res = {1'b1, 4'h0};
      ScKeyC: res = {1'b1, 4'hB};
      ScKeyV: res = {1'b1, 4'hF};
      default: res = 5'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Small synchronous FIFO of 4-bit key events.
// Ports: clk_sys, reset (sync, active-high), push/din, pop/dout, flush,
// empty, full. Push while full is dropped unless a pop happens in the same
// cycle; pop while empty is ignored; flush discards any same-cycle push/pop.
module kp_event_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic [3:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne   = 1;
  localparam logic [PtrW:0]   CntOne   = 1;
  localparam logic [PtrW:0]   CntDepth = Depth;

  logic [3:0]      mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_eff, pop_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntDepth);
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign pop_eff  = pop & ~empty & ~flush;
  assign push_eff = push & (~full | pop_eff) & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push_eff && !pop_eff)      count_d = count_q + CntOne;
      else if (pop_eff && !push_eff) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_eff) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ps2_chip8_keypad.sv
// Turns decoded PS/2 key events into the CHIP-8 hex keypad state, queues
// fresh hex presses for Fx0A, and decodes F1 (OSD toggle) and F12 (CPU reset).
// Ports: clk_sys, reset (sync, active-high); kb_interrupt/scancode/released/
// extended from the PS/2 receiver; keypad (held keys); key_valid/key_code/
// key_rd/key_flush/key_overflow for the press queue; osd_toggle (pulse),
// cpu_reset_req (level).
module ps2_chip8_keypad
  import chip8_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        kb_interrupt,
  input  logic [7:0]  scancode,
  input  logic        released,
  input  logic        extended,
  output logic [15:0] keypad,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_rd,
  input  logic        key_flush,
  output logic        key_overflow,
  output logic        osd_toggle,
  output logic        cpu_reset_req
);

  logic [4:0]  hex;
  logic        hex_hit, fn_ev;
  logic [3:0]  hex_key;
  logic [15:0] keypad_q, keypad_d;
  logic        push;
  logic        fifo_empty, fifo_full;
  logic        overflow_q, overflow_d;
  logic        osd_q, osd_d;
  logic        cpu_rst_q, cpu_rst_d;

  assign hex     = hex_decode(scancode);
  assign hex_hit = kb_interrupt & ~extended & hex[4];
  assign hex_key = hex[3:0];
  assign fn_ev   = kb_interrupt & ~extended;

  always_comb begin
    keypad_d = keypad_q;
    push     = 1'b0;
    if (hex_hit) begin
      if (released) begin
        keypad_d[hex_key] = 1'b0;
      end else begin
        keypad_d[hex_key] = 1'b1;
        // Only a fresh press is queued; typematic repeats are swallowed.
        push = ~keypad_q[hex_key];
      end
    end
    overflow_d = push & fifo_full & ~key_rd & ~key_flush;
    osd_d      = fn_ev & ~released & (scancode == ScF1);
    cpu_rst_d  = cpu_rst_q;
    if (fn_ev && scancode == ScF12) cpu_rst_d = ~released;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      keypad_q   <= '0;
      overflow_q <= 1'b0;
      osd_q      <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      keypad_q   <= keypad_d;
      overflow_q <= overflow_d;
      osd_q      <= osd_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  kp_event_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (hex_key),
    .pop     (key_rd),
    .flush   (key_flush),
    .dout    (key_code),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign keypad        = keypad_q;
  assign key_valid     = ~fifo_empty;
  assign key_overflow  = overflow_q;
  assign osd_toggle    = osd_q;
  assign cpu_reset_req = cpu_rst_q;

endmodule

// File: tb/tb_ps2_chip8_keypad.sv
module tb_ps2_chip8_keypad;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        kb_interrupt = 1'b0;
  logic [7:0]  scancode = 8'h00;
  logic        released = 1'b0;
  logic        extended = 1'b0;
  logic [15:0] keypad;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_rd = 1'b0;
  logic        key_flush = 1'b0;
  logic        key_overflow;
  logic        osd_toggle;
  logic        cpu_reset_req;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_chip8_keypad #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .kb_interrupt  (kb_interrupt),
    .scancode      (scancode),
    .released      (released),
    .extended      (extended),
    .keypad        (keypad),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_rd        (key_rd),
    .key_flush     (key_flush),
    .key_overflow  (key_overflow),
    .osd_toggle    (osd_toggle),
    .cpu_reset_req (cpu_reset_req)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic irq, input logic [7:0] sc, input logic rel, input logic ext,
                     input logic rd, input logic fl);
    kb_interrupt = irq;
    scancode     = sc;
    released     = rel;
    extended     = ext;
    key_rd       = rd;
    key_flush    = fl;
    @(posedge clk_sys);
    #1;
    kb_interrupt = 1'b0;
    released     = 1'b0;
    extended     = 1'b0;
    key_rd       = 1'b0;
    key_flush    = 1'b0;
  endtask

  task automatic make(input logic [7:0] sc);
    cyc(1'b1, sc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic brk(input logic [7:0] sc);
    cyc(1'b1, sc, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk_sys);
    #1;
    check_eq("rst_keypad", keypad, 16'h0000);
    check_eq("rst_valid", {15'b0, key_valid}, 16'd0);
    check_eq("rst_code", {12'b0, key_code}, 16'd0);
    check_eq("rst_ovf", {15'b0, key_overflow}, 16'd0);
    check_eq("rst_osd", {15'b0, osd_toggle}, 16'd0);
    check_eq("rst_cpu", {15'b0, cpu_reset_req}, 16'd0);
    reset = 1'b0;

    // Single press of A -> key 7
    make(8'h1C);
    check_eq("a_keypad", keypad, 16'h0080);
    check_eq("a_valid", {15'b0, key_valid}, 16'd1);
    check_eq("a_code", {12'b0, key_code}, 16'd7);

    // Typematic repeats then break: one entry only
    make(8'h1C);
    make(8'h1C);
    brk(8'h1C);
    check_eq("rep_keypad", keypad, 16'h0000);
    check_eq("rep_valid", {15'b0, key_valid}, 16'd1);
    check_eq("rep_code", {12'b0, key_code}, 16'd7);
    pop();
    check_eq("rep_empty", {15'b0, key_valid}, 16'd0);

    // Pop on empty queue is ignored
    pop();
    check_eq("pop_empty", {15'b0, key_valid}, 16'd0);

    // Five distinct presses into a 4-deep queue
    make(8'h16);
    make(8'h1E);
    make(8'h26);
    make(8'h25);
    check_eq("ovf_not_yet", {15'b0, key_overflow}, 16'd0);
    make(8'h15);
    check_eq("ovf_pulse", {15'b0, key_overflow}, 16'd1);
    check_eq("ovf_keypad", keypad, 16'h101E);
    idle();
    check_eq("ovf_clear", {15'b0, key_overflow}, 16'd0);
    check_eq("q_1", {12'b0, key_code}, 16'h1);
    pop();
    check_eq("q_2", {12'b0, key_code}, 16'h2);
    pop();
    check_eq("q_3", {12'b0, key_code}, 16'h3);
    pop();
    check_eq("q_c", {12'b0, key_code}, 16'hC);
    check_eq("q_c_valid", {15'b0, key_valid}, 16'd1);
    pop();
    check_eq("q_drained", {15'b0, key_valid}, 16'd0);

    brk(8'h16);
    brk(8'h1E);
    brk(8'h26);
    brk(8'h25);
    brk(8'h15);
    check_eq("all_up", keypad, 16'h0000);

    // Fill with A,0,B,2 then press V (F) while popping
    make(8'h1A);
    make(8'h22);
    make(8'h21);
    make(8'h1E);
    check_eq("full_head", {12'b0, key_code}, 16'hA);
    cyc(1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("pp_ovf", {15'b0, key_overflow}, 16'd0);
    check_eq("pp_keypad", keypad, 16'h8C05);
    check_eq("pp_0", {12'b0, key_code}, 16'h0);
    pop();
    check_eq("pp_b", {12'b0, key_code}, 16'hB);
    pop();
    check_eq("pp_2", {12'b0, key_code}, 16'h2);
    pop();
    check_eq("pp_f", {12'b0, key_code}, 16'hF);
    check_eq("pp_f_valid", {15'b0, key_valid}, 16'd1);
    pop();
    check_eq("pp_drained", {15'b0, key_valid}, 16'd0);

    // Extended code ignored
    cyc(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("ext_keypad", keypad, 16'h8C05);
    check_eq("ext_valid", {15'b0, key_valid}, 16'd0);

    // F1 pulse, F12 level
    make(8'h05);
    check_eq("osd_pulse", {15'b0, osd_toggle}, 16'd1);
    idle();
    check_eq("osd_clear", {15'b0, osd_toggle}, 16'd0);
    brk(8'h05);
    check_eq("osd_brk", {15'b0, osd_toggle}, 16'd0);
    make(8'h07);
    check_eq("cpu_set", {15'b0, cpu_reset_req}, 16'd1);
    idle();
    check_eq("cpu_hold", {15'b0, cpu_reset_req}, 16'd1);
    brk(8'h07);
    check_eq("cpu_clr", {15'b0, cpu_reset_req}, 16'd0);

    // Reset with state and a simultaneous strobe
    make(8'h1C);
    make(8'h07);
    check_eq("pre_rst_valid", {15'b0, key_valid}, 16'd1);
    reset = 1'b1;
    make(8'h05);
    check_eq("r_keypad", keypad, 16'h0000);
    check_eq("r_valid", {15'b0, key_valid}, 16'd0);
    check_eq("r_code", {12'b0, key_code}, 16'd0);
    check_eq("r_osd", {15'b0, osd_toggle}, 16'd0);
    check_eq("r_cpu", {15'b0, cpu_reset_req}, 16'd0);
    reset = 1'b0;

    // Flush with a simultaneous press
    make(8'h1B);
    check_eq("fl_pre_valid", {15'b0, key_valid}, 16'd1);
    cyc(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("fl_valid", {15'b0, key_valid}, 16'd0);
    check_eq("fl_keypad", keypad, 16'h0300);
    idle();
    check_eq("fl_stays", {15'b0, key_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
